collision_monitor: RTL and testbench
====================================

Name: collision_monitor

Overview:
- Parametrised player/hazard collision monitor for the grid game. Samples the player layer and the hazard layer at the player's cell. Confirms a crash only after it persists for a set number of cycles.
- Manages lives, a respawn pulse, a post-crash grace window counted in game ticks, and game-over.
- Sits between the pixel-layer generators and the game-control / display logic. Its outputs are the single source of truth for crash, respawn and game-over.

Parameters:
- ROWS, 16, grid rows
- COLS, 16, grid columns
- LIVES, 3, lives loaded on start (>=1)
- CONFIRM_CYCLES, 2, consecutive overlapping clk cycles needed to confirm a crash (>=1)
- GRACE_TICKS, 4, game ticks of invulnerability after a non-fatal crash (0 = none)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: (re)start game
- tick  in  1  one-cycle game-step strobe
- player_pixels  in  ROWS x COLS  player layer
- hazard_pixels  in  ROWS x COLS  hazard (car) layer
- player_row  in  $clog2(ROWS)  player row index
- player_col  in  $clog2(COLS)  player column index
- crash_pulse  out  1  one cycle per confirmed crash
- respawn  out  1  one-cycle request to return the player to the start cell
- grace_active  out  1  high while crashes are ignored
- game_over  out  1  high in OVER state
- lives_left  out  $clog2(LIVES+1)  remaining lives

Behaviour:
- Reset (asynchronous, reset_n=0) sets:
  - state=IDLE, lives_left=LIVES, hit_cnt=0, grace_cnt=0
  - crash_pulse, respawn, grace_active and game_over all 0.
- Raw hit:
  - raw = player_pixels[player_row][player_col] & hazard_pixels[player_row][player_col].
  - Forced to 0 if player_row>=ROWS or player_col>=COLS.
  - Registered into hit_q, giving 1 cycle of latency.
- hit_cnt:
  - Counts consecutive cycles with hit_q=1 while in PLAY.
  - Cleared when hit_q=0, and on any exit from PLAY.
  - Saturates at CONFIRM_CYCLES.
- Crash is confirmed in PLAY on the cycle hit_q=1 and hit_cnt==CONFIRM_CYCLES-1. That same-edge registration sets:
  - crash_pulse=1 for exactly 1 cycle;
  - lives_left decrements by 1, never below 0.
- States:
  - IDLE: all outputs low. start -> PLAY; lives_left=LIVES.
  - PLAY: confirmed crash with lives_left==1 -> OVER; lives_left=0, game_over=1. Confirmed crash with lives_left>1 -> HIT.
  - HIT: lasts one cycle; respawn=1. Loads grace_cnt=GRACE_TICKS. Goes -> GRACE if GRACE_TICKS>0, otherwise -> PLAY.
  - GRACE: grace_active=1 and hit_q is ignored. Each tick decrements grace_cnt. A tick with grace_cnt==1 -> PLAY on the next edge.
  - OVER: game_over held at 1 and hits are ignored. start -> PLAY; lives reloaded, game_over=0.
- start priority:
  - start in any state has priority over a same-cycle crash.
  - Effect: -> PLAY, lives_left=LIVES, hit_cnt=0, grace_cnt=0. crash_pulse, respawn and grace_active are 0 next cycle.
- Overlap gating: overlap persisting through GRACE into PLAY starts counting afresh from hit_cnt=0 on PLAY entry.
- tick outside GRACE has no effect.
- Reset mid-game returns to IDLE immediately and asynchronously.
- Output timing: all outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: COLLISION_MONITOR_CRASH_COUNT_EN.
- Defined:
  - Adds output crash_total, 8 bits.
  - Increments on every crash_pulse and saturates at 255.
  - Cleared to 0 by reset and by start.
  - Also adds output last_crash_row / last_crash_col, same widths as player_row/player_col. These latch the player position sampled into hit_q on the confirming cycle; reset value is 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, reset_n=0 then 1, start pulse -> lives_left=3, game_over=0, all pulses 0.
- Set row=7, col=2; hazard[7][2]=1 and player[7][2]=1 held for 1 cycle only -> no crash_pulse. Held for 2 cycles -> crash_pulse 1 cycle at the 3rd edge after overlap begins; lives_left=2; respawn next cycle; grace_active=1.
- In GRACE, hold overlap at [7][2] and give 4 ticks -> no crash_pulse during GRACE. Return to PLAY after the 4th tick. Continued overlap -> new crash 2 cycles later, lives_left=1.
- Third confirmed crash -> lives_left=0, game_over=1, no respawn. Further overlap -> no pulses. start -> lives_left=3, game_over=0.
- player_row=15, col=15 with only the hazard layer set -> no crash. Overlap with start asserted on the confirming cycle -> no crash_pulse, lives_left=3.
- With COLLISION_MONITOR_CRASH_COUNT_EN: 2 crashes at [7][2] then [5][3] -> crash_total=2, last_crash_row=5, last_crash_col=3. start -> crash_total=0.

Source files
------------

// File: rtl/collision_monitor.sv
// -----------------------------------------------------------------------------
// collision_monitor
//
// Player/hazard collision monitor for the grid game. The player and hazard
// pixel layers are sampled at the player's cell. A crash is only confirmed
// once the overlap has lasted CONFIRM_CYCLES consecutive clock cycles. The
// block also tracks lives, issues a respawn request and a post-crash grace
// window counted in game ticks, and flags game-over. It is the single source
// of truth for crash, respawn and game-over. Every output is driven straight
// from a flop, so no input reaches an output without passing through a clock
// edge.
//
// Pixel layers are flattened row-major: cell [r][c] is bit r*COLS + c.
//
// Optional feature (macro COLLISION_MONITOR_CRASH_COUNT_EN): adds a saturating
// 8-bit crash counter and the row/column of the most recent confirmed crash.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle (re)start pulse
//   tick           in   one-cycle game-step strobe
//   player_pixels  in   ROWS*COLS player layer
//   hazard_pixels  in   ROWS*COLS hazard layer
//   player_row     in   player row index
//   player_col     in   player column index
//   crash_pulse    out  one cycle per confirmed crash
//   respawn        out  one-cycle request to return to the start cell
//   grace_active   out  high while crashes are ignored
//   game_over      out  high in the OVER state
//   lives_left     out  remaining lives
//   crash_total    out  (optional) saturating crash count
//   last_crash_row out  (optional) row of the last confirmed crash
//   last_crash_col out  (optional) column of the last confirmed crash
// -----------------------------------------------------------------------------
module collision_monitor #(
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int LIVES          = 3,
  parameter int CONFIRM_CYCLES = 2,
  parameter int GRACE_TICKS    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        tick,
  input  logic [ROWS*COLS-1:0]        player_pixels,
  input  logic [ROWS*COLS-1:0]        hazard_pixels,
  input  logic [$clog2(ROWS)-1:0]     player_row,
  input  logic [$clog2(COLS)-1:0]     player_col,
  output logic                        crash_pulse,
  output logic                        respawn,
  output logic                        grace_active,
  output logic                        game_over,
  output logic [$clog2(LIVES+1)-1:0]  lives_left
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
  ,
  output logic [7:0]                  crash_total,
  output logic [$clog2(ROWS)-1:0]     last_crash_row,
  output logic [$clog2(COLS)-1:0]     last_crash_col
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int LW = $clog2(LIVES + 1);
  localparam int HW = $clog2(CONFIRM_CYCLES + 1);
  localparam int GW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
  localparam int IW = $clog2(ROWS * COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_HIT,
    S_GRACE,
    S_OVER
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [HW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [GW-1:0]   grace_cnt_q, grace_cnt_d;
  logic            hit_q;
  logic            crash_q, crash_d;
  logic            respawn_q, respawn_d;
  logic            grace_active_q;
  logic            game_over_q;

  logic            in_range;
  logic [IW-1:0]   pix_idx;
  logic            raw_hit;
  logic            confirm;

  // Raw overlap at the player's cell. An off-grid position never hits, so the
  // (possibly out-of-range) index is harmless once gated by in_range.
  always_comb begin
    in_range = (int'(player_row) < ROWS) && (int'(player_col) < COLS);
    pix_idx  = IW'(int'(player_row) * COLS + int'(player_col));
    raw_hit  = in_range & player_pixels[pix_idx] & hazard_pixels[pix_idx];
  end

  // The confirming cycle is the CONFIRM_CYCLES-th consecutive registered hit.
  assign confirm = (state_q == S_PLAY) && hit_q &&
                   (hit_cnt_q == HW'(CONFIRM_CYCLES - 1));

  // NOTE: every variable written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    hit_cnt_d   = '0;
    grace_cnt_d = grace_cnt_q;
    crash_d     = 1'b0;
    respawn_d   = 1'b0;

    if (start) begin
      // A restart wins over anything else happening in the same cycle,
      // including a crash that would otherwise confirm now.
      state_d     = S_PLAY;
      lives_d     = LW'(LIVES);
      grace_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_PLAY: begin
          if (confirm) begin
            crash_d = 1'b1;
            lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
            state_d = (lives_q <= LW'(1)) ? S_OVER : S_HIT;
          end else if (hit_q) begin
            hit_cnt_d = (hit_cnt_q < HW'(CONFIRM_CYCLES)) ? hit_cnt_q + 1'b1
                                                          : hit_cnt_q;
          end
        end
        S_HIT: begin
          respawn_d   = 1'b1;
          grace_cnt_d = GW'(GRACE_TICKS);
          state_d     = (GRACE_TICKS > 0) ? S_GRACE : S_PLAY;
        end
        S_GRACE: begin
          // hit_q is deliberately ignored; hit_cnt stays 0 so a lingering
          // overlap starts counting afresh once PLAY is re-entered.
          if (tick) begin
            grace_cnt_d = (grace_cnt_q != '0) ? grace_cnt_q - 1'b1 : '0;
            if (grace_cnt_q <= GW'(1)) state_d = S_PLAY;
          end
        end
        S_OVER: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      lives_q        <= LW'(LIVES);
      hit_cnt_q      <= '0;
      grace_cnt_q    <= '0;
      hit_q          <= 1'b0;
      crash_q        <= 1'b0;
      respawn_q      <= 1'b0;
      grace_active_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      hit_cnt_q      <= hit_cnt_d;
      grace_cnt_q    <= grace_cnt_d;
      hit_q          <= raw_hit;
      crash_q        <= crash_d;
      respawn_q      <= respawn_d;
      // Level outputs are registered from the next state so they line up
      // with the state they describe.
      grace_active_q <= (state_d == S_GRACE);
      game_over_q    <= (state_d == S_OVER);
    end
  end

  assign crash_pulse  = crash_q;
  assign respawn      = respawn_q;
  assign grace_active = grace_active_q;
  assign game_over    = game_over_q;
  assign lives_left   = lives_q;

`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
  // Position registered alongside hit_q, so the latched crash location is the
  // one whose overlap actually confirmed the crash.
  logic [RW-1:0] row_q, last_row_q;
  logic [CW-1:0] col_q, last_col_q;
  logic [7:0]    total_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q      <= '0;
      col_q      <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      total_q    <= '0;
    end else begin
      row_q <= player_row;
      col_q <= player_col;
      if (start) begin
        total_q <= '0;
      end else if (crash_d) begin
        if (total_q != 8'hFF) total_q <= total_q + 8'd1;
        last_row_q <= row_q;
        last_col_q <= col_q;
      end
    end
  end

  assign crash_total    = total_q;
  assign last_crash_row = last_row_q;
  assign last_crash_col = last_col_q;
`else
  // Crash statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// -----------------------------------------------------------------------------
// tb_collision_monitor
//
// Directed bench for collision_monitor with default parameters. Each step sets
// inputs, pushes the expected registered outputs onto a scoreboard queue, and
// after the following rising edge pops the entry and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_collision_monitor;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic                 tick;
  logic [ROWS*COLS-1:0] player_pixels;
  logic [ROWS*COLS-1:0] hazard_pixels;
  logic [3:0]           player_row;
  logic [3:0]           player_col;
  logic                 crash_pulse;
  logic                 respawn;
  logic                 grace_active;
  logic                 game_over;
  logic [1:0]           lives_left;
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
  logic [7:0]           crash_total;
  logic [3:0]           last_crash_row;
  logic [3:0]           last_crash_col;
`endif

  collision_monitor dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .tick          (tick),
    .player_pixels (player_pixels),
    .hazard_pixels (hazard_pixels),
    .player_row    (player_row),
    .player_col    (player_col),
    .crash_pulse   (crash_pulse),
    .respawn       (respawn),
    .grace_active  (grace_active),
    .game_over     (game_over),
    .lives_left    (lives_left)
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
    ,
    .crash_total   (crash_total),
    .last_crash_row(last_crash_row),
    .last_crash_col(last_crash_col)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       crash;
    logic       resp;
    logic       grace;
    logic       over;
    logic [1:0] lives;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Push the expected outputs, let one edge happen, pop and compare.
  task automatic expect_cycle(input logic c, input logic r, input logic g,
                              input logic o, input logic [1:0] l);
    exp_t e;
    e.crash = c;
    e.resp  = r;
    e.grace = g;
    e.over  = o;
    e.lives = l;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("crash_pulse",  32'(crash_pulse),  32'(e.crash));
    check("respawn",      32'(respawn),      32'(e.resp));
    check("grace_active", 32'(grace_active), 32'(e.grace));
    check("game_over",    32'(game_over),    32'(e.over));
    check("lives_left",   32'(lives_left),   32'(e.lives));
  endtask

  task automatic set_cell(input int r, input int c, input logic p,
                          input logic h);
    player_pixels = '0;
    hazard_pixels = '0;
    player_row    = r[3:0];
    player_col    = c[3:0];
    player_pixels[r*COLS+c] = p;
    hazard_pixels[r*COLS+c] = h;
  endtask

  task automatic grace_ticks(input logic [1:0] l);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      expect_cycle(1'b0, 1'b0, (i < 3), 1'b0, l);
      tick = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    set_cell(0, 0, 1'b0, 1'b0);
    #12;
    check("reset crash_pulse",  32'(crash_pulse),  32'd0);
    check("reset respawn",      32'(respawn),      32'd0);
    check("reset grace_active", 32'(grace_active), 32'd0);
    check("reset game_over",    32'(game_over),    32'd0);
    check("reset lives_left",   32'(lives_left),   32'd3);
    #5 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: start loads lives and enters PLAY.
    start = 1'b1;
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b0;

    // Overlap for a single cycle never confirms.
    set_cell(7, 2, 1'b0, 1'b0);
    expect_cycle(0, 0, 0, 0, 2'd3);
    set_cell(7, 2, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd3);
    set_cell(7, 2, 1'b0, 1'b0);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);

    // Sustained overlap: crash on the third edge, then respawn + grace.
    set_cell(7, 2, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(1, 0, 0, 0, 2'd2);
    expect_cycle(0, 1, 1, 0, 2'd2);
    expect_cycle(0, 0, 1, 0, 2'd2);   // no tick: grace holds
    grace_ticks(2'd2);                // overlap held throughout, no crash

    // Continued overlap counts afresh from PLAY entry.
    expect_cycle(0, 0, 0, 0, 2'd2);
    expect_cycle(1, 0, 0, 0, 2'd1);
    expect_cycle(0, 1, 1, 0, 2'd1);
    grace_ticks(2'd1);

    // Last life: game over, no respawn, further overlap ignored.
    expect_cycle(0, 0, 0, 0, 2'd1);
    expect_cycle(1, 0, 0, 1, 2'd0);
    for (int i = 0; i < 4; i++) expect_cycle(0, 0, 0, 1, 2'd0);
    start = 1'b1;
    set_cell(7, 2, 1'b0, 1'b0);
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b0;

    // Hazard only at the far corner, ticks outside GRACE: no effect.
    set_cell(15, 15, 1'b0, 1'b1);
    tick = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle(0, 0, 0, 0, 2'd3);
    tick = 1'b0;

    // start on the confirming cycle wins over the crash.
    set_cell(15, 15, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b1;
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b0;
    set_cell(15, 15, 1'b0, 1'b0);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);

    // Two crashes at different cells, then restart.
    start = 1'b1;
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b0;
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
    check("crash_total after start", 32'(crash_total), 32'd0);
`endif
    set_cell(7, 2, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(1, 0, 0, 0, 2'd2);
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
    check("crash_total 1", 32'(crash_total),    32'd1);
    check("last_row 1",    32'(last_crash_row), 32'd7);
    check("last_col 1",    32'(last_crash_col), 32'd2);
`endif
    expect_cycle(0, 1, 1, 0, 2'd2);
    set_cell(7, 2, 1'b0, 1'b0);
    grace_ticks(2'd2);
    set_cell(5, 3, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd2);
    expect_cycle(0, 0, 0, 0, 2'd2);
    expect_cycle(1, 0, 0, 0, 2'd1);
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
    check("crash_total 2", 32'(crash_total),    32'd2);
    check("last_row 2",    32'(last_crash_row), 32'd5);
    check("last_col 2",    32'(last_crash_col), 32'd3);
`endif
    expect_cycle(0, 1, 1, 0, 2'd1);
    start = 1'b1;
    set_cell(5, 3, 1'b0, 1'b0);
    expect_cycle(0, 0, 0, 0, 2'd3);
    start = 1'b0;
`ifdef COLLISION_MONITOR_CRASH_COUNT_EN
    check("crash_total cleared", 32'(crash_total), 32'd0);
`endif

    // Asynchronous reset mid-game while crash_pulse is high.
    set_cell(5, 3, 1'b1, 1'b1);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(0, 0, 0, 0, 2'd3);
    expect_cycle(1, 0, 0, 0, 2'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async reset crash_pulse", 32'(crash_pulse), 32'd0);
    check("async reset lives_left",  32'(lives_left),  32'd3);
    check("async reset game_over",   32'(game_over),   32'd0);
    @(posedge clk);
    #1;
    check("held reset respawn", 32'(respawn),      32'd0);
    check("held reset grace",   32'(grace_active), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
